sync_stream_fifo: RTL and testbench

//  Parametrised single-clock FIFO for pixel/burst data between the camera capture path and
//  the HDR merge / memory-write stages. Generalises the camera CDC FIFO in width, depth and

---
 rtl/sync_stream_fifo_pkg.sv | 13 +
 rtl/sync_stream_fifo_if.sv | 31 +++
 rtl/sync_fifo_mem.sv | 23 ++
 rtl/sync_stream_fifo.sv | 126 ++++++++++++
 tb/tb_sync_stream_fifo.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/sync_stream_fifo_pkg.sv
// Shared constants for the capture/HDR stream FIFOs and a parameter sanity helper.
package sync_stream_fifo_pkg;

    localparam int unsigned PIXEL_BUS_W    = 256;
    localparam int unsigned FIFO_DEPTH_DEF = 16;
    localparam int unsigned CAP_FIFO_DEPTH = 16;
    localparam int unsigned HDR_FIFO_DEPTH = 32;

    function automatic bit is_pow2(input int unsigned v);
        return (v >= 2) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/sync_stream_fifo_if.sv
// Stream FIFO control/data/status bundle; master drives requests, slave is the FIFO.
interface sync_stream_fifo_if #(
    parameter int unsigned DATA_W = 256,
    parameter int unsigned CW     = 5
);
    logic              clr;
    logic              wr_en;
    logic [DATA_W-1:0] data_in;
    logic              rd_en;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              empty;
    logic              full;
    logic              almost_full;
    logic              almost_empty;
    logic [CW-1:0]     count;
    logic              overflow;
    logic              underflow;

    modport master (
        output clr, wr_en, data_in, rd_en,
        input  data_out, data_valid, empty, full, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  clr, wr_en, data_in, rd_en,
        output data_out, data_valid, empty, full, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_mem.sv
// DEPTH x DATA_W register array: synchronous write port, asynchronous read port.
module sync_fifo_mem #(
    parameter int unsigned DATA_W = 256,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_stream_fifo.sv
// Single-clock stream FIFO with standard or FWFT read, fill count, thresholds,
// sticky overflow/underflow and synchronous flush.
module sync_stream_fifo
    import sync_stream_fifo_pkg::*;
#(
    parameter int unsigned DATA_W    = PIXEL_BUS_W,
    parameter int unsigned DEPTH     = FIFO_DEPTH_DEF,
    parameter int unsigned FWFT      = 0,
    parameter int unsigned AFULL_TH  = DEPTH - 2,
    parameter int unsigned AEMPTY_TH = 2
) (
    input logic              clk,
    input logic              rst_n,
    sync_stream_fifo_if.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [AW:0] AF_V = CW'(AFULL_TH);
    localparam logic [AW:0] AE_V = CW'(AEMPTY_TH);
    localparam logic        AF_RST = (AFULL_TH == 0);

    if (!is_pow2(DEPTH) || (AFULL_TH > DEPTH) || (AEMPTY_TH >= DEPTH)) begin : g_param_err
        $error("sync_stream_fifo: DEPTH must be a power of 2 >= 2, AFULL_TH <= DEPTH, AEMPTY_TH < DEPTH");
    end

    logic [AW:0]       wr_ptr, rd_ptr;
    logic [AW:0]       wr_ptr_nx, rd_ptr_nx, count_nx;
    logic [AW:0]       count_q;
    logic              wr_acc, rd_acc;
    logic              empty_q, full_q, afull_q, aempty_q;
    logic              ovf_q, unf_q;
    logic              full_nx;
    logic [DATA_W-1:0] rdata;

    // Acceptance uses the registered (pre-edge) flags; next pointers drive the post-edge flags.
    always_comb begin
        wr_acc    = bus.wr_en & ~full_q;
        rd_acc    = bus.rd_en & ~empty_q;
        wr_ptr_nx = wr_ptr + CW'(wr_acc);
        rd_ptr_nx = rd_ptr + CW'(rd_acc);
        count_nx  = wr_ptr_nx - rd_ptr_nx;
        full_nx   = (wr_ptr_nx[AW] != rd_ptr_nx[AW]) &&
                    (wr_ptr_nx[AW-1:0] == rd_ptr_nx[AW-1:0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            afull_q  <= AF_RST;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else if (bus.clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            afull_q  <= AF_RST;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr_nx;
            rd_ptr   <= rd_ptr_nx;
            count_q  <= count_nx;
            empty_q  <= (wr_ptr_nx == rd_ptr_nx);
            full_q   <= full_nx;
            afull_q  <= (count_nx >= AF_V);
            aempty_q <= (count_nx <= AE_V);
            ovf_q    <= ovf_q | (bus.wr_en & full_q);
            unf_q    <= unf_q | (bus.rd_en & empty_q);
        end
    end

    sync_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc & ~bus.clr),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (bus.data_in),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rdata)
    );

    if (FWFT != 0) begin : g_fwft
        // Head word is presented straight from the array whenever the FIFO holds data.
        assign bus.data_out   = rdata;
        assign bus.data_valid = ~empty_q;
    end else begin : g_std
        logic [DATA_W-1:0] dout_q;
        logic              dv_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dout_q <= '0;
                dv_q   <= 1'b0;
            end else if (bus.clr) begin
                dv_q   <= 1'b0;
            end else begin
                dv_q <= rd_acc;
                if (rd_acc) dout_q <= rdata;
            end
        end

        assign bus.data_out   = dout_q;
        assign bus.data_valid = dv_q;
    end

    assign bus.empty        = empty_q;
    assign bus.full         = full_q;
    assign bus.almost_full  = afull_q;
    assign bus.almost_empty = aempty_q;
    assign bus.count        = count_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;

endmodule

// File: tb/tb_sync_stream_fifo.sv
// Drives four FIFO configurations (std/FWFT x two threshold sets) with one stimulus
// stream and compares each against a queue-based model every cycle.
module tb_sync_stream_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       t_clr, t_wr, t_rd;
    logic [7:0] t_din;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sync_stream_fifo_if #(.DATA_W(8), .CW(3)) if_a ();
    sync_stream_fifo_if #(.DATA_W(8), .CW(3)) if_b ();
    sync_stream_fifo_if #(.DATA_W(8), .CW(3)) if_c ();
    sync_stream_fifo_if #(.DATA_W(8), .CW(3)) if_d ();

    assign if_a.clr = t_clr; assign if_a.wr_en = t_wr; assign if_a.rd_en = t_rd; assign if_a.data_in = t_din;
    assign if_b.clr = t_clr; assign if_b.wr_en = t_wr; assign if_b.rd_en = t_rd; assign if_b.data_in = t_din;
    assign if_c.clr = t_clr; assign if_c.wr_en = t_wr; assign if_c.rd_en = t_rd; assign if_c.data_in = t_din;
    assign if_d.clr = t_clr; assign if_d.wr_en = t_wr; assign if_d.rd_en = t_rd; assign if_d.data_in = t_din;

    sync_stream_fifo #(.DATA_W(8), .DEPTH(4), .FWFT(0), .AFULL_TH(3), .AEMPTY_TH(1))
        u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
    sync_stream_fifo #(.DATA_W(8), .DEPTH(4), .FWFT(1), .AFULL_TH(3), .AEMPTY_TH(1))
        u_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
    sync_stream_fifo #(.DATA_W(8), .DEPTH(4), .FWFT(0), .AFULL_TH(4), .AEMPTY_TH(0))
        u_c (.clk(clk), .rst_n(rst_n), .bus(if_c));
    sync_stream_fifo #(.DATA_W(8), .DEPTH(4), .FWFT(1), .AFULL_TH(4), .AEMPTY_TH(0))
        u_d (.clk(clk), .rst_n(rst_n), .bus(if_d));

    // Behavioural model: contents as a queue, plus sticky flags and the std-mode output register.
    logic [7:0] mq[$];
    logic       m_ovf, m_unf, m_dv;
    logic [7:0] m_dout;

    task automatic model_reset();
        mq.delete();
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_dv   = 1'b0;
        m_dout = 8'h00;
    endtask

    task automatic model_step();
        int sz;
        if (!rst_n) return;
        sz = mq.size();
        if (t_clr) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            m_dv  = 1'b0;
        end else begin
            if (t_wr && sz == 4) m_ovf = 1'b1;
            if (t_rd && sz == 0) m_unf = 1'b1;
            m_dv = 1'b0;
            if (t_rd && sz > 0) begin
                m_dout = mq.pop_front();
                m_dv   = 1'b1;
            end
            if (t_wr && sz < 4) mq.push_back(t_din);
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_inst(input string nm, input int fw, input int af, input int ae,
                              input logic [2:0] cnt, input logic emp, input logic ful,
                              input logic afl, input logic ael, input logic ovf,
                              input logic unf, input logic dv, input logic [7:0] dout);
        int sz;
        sz = mq.size();
        chk({nm, " count"},        int'(cnt), sz);
        chk({nm, " empty"},        int'(emp), int'(sz == 0));
        chk({nm, " full"},         int'(ful), int'(sz == 4));
        chk({nm, " almost_full"},  int'(afl), int'(sz >= af));
        chk({nm, " almost_empty"}, int'(ael), int'(sz <= ae));
        chk({nm, " overflow"},     int'(ovf), int'(m_ovf));
        chk({nm, " underflow"},    int'(unf), int'(m_unf));
        if (fw != 0) begin
            chk({nm, " data_valid"}, int'(dv), int'(sz != 0));
            if (sz != 0) chk({nm, " data_out"}, int'(dout), int'(mq[0]));
        end else begin
            chk({nm, " data_valid"}, int'(dv), int'(m_dv));
            chk({nm, " data_out"},   int'(dout), int'(m_dout));
        end
    endtask

    task automatic compare_all();
        check_inst("A", 0, 3, 1, if_a.count, if_a.empty, if_a.full, if_a.almost_full,
                   if_a.almost_empty, if_a.overflow, if_a.underflow, if_a.data_valid, if_a.data_out);
        check_inst("B", 1, 3, 1, if_b.count, if_b.empty, if_b.full, if_b.almost_full,
                   if_b.almost_empty, if_b.overflow, if_b.underflow, if_b.data_valid, if_b.data_out);
        check_inst("C", 0, 4, 0, if_c.count, if_c.empty, if_c.full, if_c.almost_full,
                   if_c.almost_empty, if_c.overflow, if_c.underflow, if_c.data_valid, if_c.data_out);
        check_inst("D", 1, 4, 0, if_d.count, if_d.empty, if_d.full, if_d.almost_full,
                   if_d.almost_empty, if_d.overflow, if_d.underflow, if_d.data_valid, if_d.data_out);
    endtask

    task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic c);
        t_wr  = w;
        t_din = d;
        t_rd  = r;
        t_clr = c;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        rst_n = 1'b0;
        t_clr = 1'b0; t_wr = 1'b0; t_rd = 1'b0; t_din = 8'h00;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        compare_all();
        chk("reset count", int'(if_a.count), 0);
        chk("reset empty", int'(if_a.empty), 1);
        chk("reset almost_empty", int'(if_c.almost_empty), 1);
        chk("reset almost_full", int'(if_c.almost_full), 0);

        // Fill and drain in standard mode
        cyc(1, 8'h11, 0, 0);
        chk("C aempty at 1", int'(if_c.almost_empty), 0);
        chk("A aempty at 1", int'(if_a.almost_empty), 1);
        cyc(1, 8'h22, 0, 0);
        cyc(1, 8'h33, 0, 0);
        chk("A afull at 3", int'(if_a.almost_full), 1);
        chk("C afull at 3", int'(if_c.almost_full), 0);
        cyc(1, 8'h44, 0, 0);
        chk("A full", int'(if_a.full), 1);
        chk("A count 4", int'(if_a.count), 4);
        chk("C afull at 4", int'(if_c.almost_full), 1);
        cyc(1, 8'h55, 0, 0);
        chk("A overflow", int'(if_a.overflow), 1);
        chk("B head after ovf", int'(if_b.data_out), 8'h11);
        cyc(0, 8'h00, 1, 0);
        chk("A rd1 data", int'(if_a.data_out), 8'h11);
        chk("A rd1 valid", int'(if_a.data_valid), 1);
        cyc(0, 8'h00, 1, 0);
        chk("A rd2 data", int'(if_a.data_out), 8'h22);
        cyc(0, 8'h00, 1, 0);
        chk("A rd3 data", int'(if_a.data_out), 8'h33);
        cyc(0, 8'h00, 1, 0);
        chk("A rd4 data", int'(if_a.data_out), 8'h44);
        chk("A empty after drain", int'(if_a.empty), 1);
        cyc(0, 8'h00, 0, 0);
        chk("A valid drops", int'(if_a.data_valid), 0);
        cyc(0, 8'h00, 1, 0);
        chk("A underflow", int'(if_a.underflow), 1);
        chk("A data held", int'(if_a.data_out), 8'h44);
        chk("A overflow sticky", int'(if_a.overflow), 1);
        cyc(0, 8'h00, 0, 1);
        chk("A clr overflow", int'(if_a.overflow), 0);
        chk("A clr underflow", int'(if_a.underflow), 0);

        // Simultaneous read/write across pointer wrap
        cyc(1, 8'h00, 0, 0);
        cyc(1, 8'h01, 0, 0);
        for (int i = 2; i < 12; i++) cyc(1, 8'(i), 1, 0);
        chk("A count steady", int'(if_a.count), 2);
        chk("A wrap data", int'(if_a.data_out), 8'h09);
        cyc(1, 8'h0C, 0, 0);
        cyc(1, 8'h0D, 0, 0);
        cyc(1, 8'h0E, 1, 0);
        chk("A full wr+rd count", int'(if_a.count), 3);
        chk("A full wr+rd ovf", int'(if_a.overflow), 1);
        chk("A full wr+rd data", int'(if_a.data_out), 8'h0A);

        // FWFT head visibility
        cyc(0, 8'h00, 0, 1);
        cyc(1, 8'hA5, 0, 0);
        chk("B fwft head", int'(if_b.data_out), 8'hA5);
        chk("B fwft not empty", int'(if_b.empty), 0);
        cyc(0, 8'h00, 1, 0);
        chk("B fwft empty after pop", int'(if_b.empty), 1);
        cyc(1, 8'hB1, 0, 0);
        cyc(1, 8'hB2, 1, 0);
        chk("B fwft b2b head", int'(if_b.data_out), 8'hB2);
        cyc(1, 8'hB3, 1, 0);
        cyc(0, 8'h00, 1, 0);

        // Randomised traffic
        for (int i = 0; i < 400; i++)
            cyc(($urandom_range(0, 99) < 55), 8'($urandom), ($urandom_range(0, 99) < 50),
                ($urandom_range(0, 59) == 0));

        // Asynchronous reset with three words stored
        cyc(0, 8'h00, 0, 1);
        cyc(1, 8'h61, 0, 0);
        cyc(1, 8'h62, 1, 0);
        cyc(1, 8'h63, 0, 0);
        cyc(1, 8'h64, 0, 0);
        chk("pre-reset count", int'(if_a.count), 3);
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk("async rst count", int'(if_b.count), 0);
        chk("async rst valid", int'(if_a.data_valid), 0);
        chk("async rst full", int'(if_a.full), 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        compare_all();

        for (int i = 0; i < 200; i++)
            cyc(($urandom_range(0, 99) < 50), 8'($urandom), ($urandom_range(0, 99) < 55), 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
